// File: rtl/exception_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : exception_ctrl
// Description : MEM-stage exception arbiter for a MIPS-style pipeline.
//               Synchronizes the hardware interrupt pins, forwards in-flight
//               mtc0 writes to Status/Cause/EPC, picks the highest-priority
//               exception, redirects the PC and flushes the pipeline. A small
//               FSM (IDLE/FLUSH/DRAIN) blocks a second exception while the
//               flush drains.
//               Optional feature: define TRAP_EXC_EN to enable the trap
//               exception (code 0x0d).
// Revision    : 1.0 - initial release
// ============================================================================
module exception_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic [5:0]  ext_int_i,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_pc_i,
  input  logic        mem_in_delayslot_i,
  input  logic        adel_if_i,
  input  logic        ri_i,
  input  logic        ov_i,
  input  logic        trap_i,
  input  logic        syscall_i,
  input  logic        break_i,
  input  logic        adel_i,
  input  logic        ades_i,
  input  logic        eret_i,
  input  logic [31:0] if_bad_addr_i,
  input  logic [31:0] mem_bad_addr_i,
  input  logic        cp0_we_i,
  input  logic [4:0]  cp0_waddr_i,
  input  logic [31:0] cp0_wdata_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        timer_int_i,
  output logic [5:0]  int_o,
  output logic [31:0] excepttype_o,
  output logic [31:0] current_inst_addr_o,
  output logic        is_in_delayslot_o,
  output logic [31:0] bad_addr_o,
  output logic        flush_o,
  output logic [31:0] newpc_o
);

  localparam logic [4:0]  CP0_STATUS   = 5'd12;
  localparam logic [4:0]  CP0_CAUSE    = 5'd13;
  localparam logic [4:0]  CP0_EPC      = 5'd14;
  localparam logic [31:0] EXC_VECTOR   = 32'hBFC0_0380;
  localparam logic [31:0] EXC_INT      = 32'h0000_0001;
  localparam logic [31:0] EXC_ADEL     = 32'h0000_0004;
  localparam logic [31:0] EXC_ADES     = 32'h0000_0005;
  localparam logic [31:0] EXC_SYSCALL  = 32'h0000_0008;
  localparam logic [31:0] EXC_BREAK    = 32'h0000_0009;
  localparam logic [31:0] EXC_RI       = 32'h0000_000a;
  localparam logic [31:0] EXC_OV       = 32'h0000_000c;
  localparam logic [31:0] EXC_TRAP     = 32'h0000_000d;
  localparam logic [31:0] EXC_ERET     = 32'h0000_000e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [5:0]  int_sync1;
  logic [5:0]  int_sync2;
  logic [31:0] status_eff;
  logic [7:0]  cause_ip_eff;
  logic [31:0] epc_eff;
  logic        int_pending;
  logic        trap_hit;
  logic        unused_bits;

  // Two-flop synchronizer for the asynchronous interrupt pins
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      int_sync1 <= 6'd0;
      int_sync2 <= 6'd0;
    end else begin
      int_sync1 <= ext_int_i;
      int_sync2 <= int_sync1;
    end
  end

  // Timer interrupt is already synchronous, so it joins after the flops
  assign int_o = {int_sync2[5] | timer_int_i, int_sync2[4:0]};

  // An mtc0 still in MEM has not reached CP0 yet; use its data directly
  assign status_eff   = (cp0_we_i && cp0_waddr_i == CP0_STATUS) ? cp0_wdata_i : cp0_status_i;
  assign cause_ip_eff = {cp0_cause_i[15:10],
                         (cp0_we_i && cp0_waddr_i == CP0_CAUSE) ? cp0_wdata_i[9:8] : cp0_cause_i[9:8]};
  assign epc_eff      = (cp0_we_i && cp0_waddr_i == CP0_EPC) ? cp0_wdata_i : cp0_epc_i;

  // IE set, EXL clear, and at least one unmasked request
  assign int_pending = status_eff[0] & ~status_eff[1] & (|(cause_ip_eff & status_eff[15:8]));

`ifdef TRAP_EXC_EN
  assign trap_hit = trap_i;
`else
  assign trap_hit = 1'b0;
`endif

  // Status/Cause bits outside IE/EXL/IM/IP carry no meaning here
  assign unused_bits = ^{status_eff[31:16], status_eff[7:2],
                         cp0_cause_i[31:16], cp0_cause_i[7:0], trap_i};

  assign current_inst_addr_o = mem_pc_i;
  assign is_in_delayslot_o   = mem_in_delayslot_i;

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Priority selection, redirect target and next-state logic
  always_comb begin
    excepttype_o = 32'd0;
    bad_addr_o   = 32'd0;
    newpc_o      = 32'd0;
    flush_o      = 1'b0;
    state_next   = state;

    // Reset gating keeps outputs quiet even though state already reads IDLE
    if (rst && state == IDLE && mem_valid_i && !stall_i) begin
      if (int_pending) begin
        excepttype_o = EXC_INT;
      end else if (adel_if_i) begin
        excepttype_o = EXC_ADEL;
        bad_addr_o   = if_bad_addr_i;
      end else if (ri_i) begin
        excepttype_o = EXC_RI;
      end else if (ov_i) begin
        excepttype_o = EXC_OV;
      end else if (trap_hit) begin
        excepttype_o = EXC_TRAP;
      end else if (syscall_i) begin
        excepttype_o = EXC_SYSCALL;
      end else if (break_i) begin
        excepttype_o = EXC_BREAK;
      end else if (adel_i) begin
        excepttype_o = EXC_ADEL;
        bad_addr_o   = mem_bad_addr_i;
      end else if (ades_i) begin
        excepttype_o = EXC_ADES;
        bad_addr_o   = mem_bad_addr_i;
      end else if (eret_i) begin
        excepttype_o = EXC_ERET;
      end
    end

    flush_o = (excepttype_o != 32'd0);
    if (flush_o) begin
      newpc_o = (excepttype_o == EXC_ERET) ? epc_eff : EXC_VECTOR;
    end

    case (state)
      IDLE:    if (flush_o) state_next = FLUSH;
      FLUSH:   state_next = DRAIN;
      DRAIN:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_exception_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_exception_ctrl
// Description : Directed self-checking bench for exception_ctrl. A tiny CP0
//               stand-in feeds int_o back into Cause.IP[7:2].
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exception_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i, mem_valid_i, mem_in_delayslot_i;
  logic [5:0]  ext_int_i;
  logic [31:0] mem_pc_i;
  logic        adel_if_i, ri_i, ov_i, trap_i, syscall_i, break_i, adel_i, ades_i, eret_i;
  logic [31:0] if_bad_addr_i, mem_bad_addr_i;
  logic        cp0_we_i;
  logic [4:0]  cp0_waddr_i;
  logic [31:0] cp0_wdata_i, cp0_status_i, cp0_cause_i, cp0_epc_i;
  logic        timer_int_i;
  logic [5:0]  int_o;
  logic [31:0] excepttype_o, current_inst_addr_o, bad_addr_o, newpc_o;
  logic        is_in_delayslot_o, flush_o;
  logic [1:0]  cause_sw;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [31:0] VEC = 32'hBFC0_0380;
`ifdef TRAP_EXC_EN
  localparam logic [31:0] TRAP_EXP      = 32'h0d;
  localparam logic [31:0] TRAP_SYS_EXP  = 32'h0d;
`else
  localparam logic [31:0] TRAP_EXP      = 32'h00;
  localparam logic [31:0] TRAP_SYS_EXP  = 32'h08;
`endif

  always #5 clk = ~clk;

  // CP0 stand-in: hardware IP bits come from int_o, software IP bits from the bench
  assign cp0_cause_i = {16'h0, int_o, cause_sw, 8'h00};

  exception_ctrl dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .ext_int_i(ext_int_i),
    .mem_valid_i(mem_valid_i), .mem_pc_i(mem_pc_i), .mem_in_delayslot_i(mem_in_delayslot_i),
    .adel_if_i(adel_if_i), .ri_i(ri_i), .ov_i(ov_i), .trap_i(trap_i),
    .syscall_i(syscall_i), .break_i(break_i), .adel_i(adel_i), .ades_i(ades_i),
    .eret_i(eret_i), .if_bad_addr_i(if_bad_addr_i), .mem_bad_addr_i(mem_bad_addr_i),
    .cp0_we_i(cp0_we_i), .cp0_waddr_i(cp0_waddr_i), .cp0_wdata_i(cp0_wdata_i),
    .cp0_status_i(cp0_status_i), .cp0_cause_i(cp0_cause_i), .cp0_epc_i(cp0_epc_i),
    .timer_int_i(timer_int_i), .int_o(int_o), .excepttype_o(excepttype_o),
    .current_inst_addr_o(current_inst_addr_o), .is_in_delayslot_o(is_in_delayslot_o),
    .bad_addr_o(bad_addr_o), .flush_o(flush_o), .newpc_o(newpc_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to 1ns after the next rising edge; inputs change and checks follow here
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_flags();
    adel_if_i = 0; ri_i = 0; ov_i = 0; trap_i = 0; syscall_i = 0; break_i = 0;
    adel_i = 0; ades_i = 0; eret_i = 0; cp0_we_i = 0; cp0_waddr_i = 5'd0;
    cp0_wdata_i = 32'd0; stall_i = 0;
  endtask

  // Let an accepted exception move the FSM to FLUSH, then idle until back in IDLE
  task automatic drain();
    tick();
    clear_flags();
    mem_valid_i = 0;
    ext_int_i   = 6'd0;
    repeat (4) tick();
  endtask

  initial begin
    rst = 0; clear_flags();
    ext_int_i = 6'd0; mem_valid_i = 1; mem_pc_i = 32'h0; mem_in_delayslot_i = 0;
    if_bad_addr_i = 32'h1111_1111; mem_bad_addr_i = 32'h2222_2222;
    cp0_status_i = 32'h0; cp0_epc_i = 32'h0; timer_int_i = 1; cause_sw = 2'b00;
    ov_i = 1; ext_int_i = 6'h3f;

    // Reset: outputs quiet even with a flag presented, timer passes through
    repeat (2) tick();
    chk("rst_int_timer", {26'd0, int_o}, 32'h20);
    chk("rst_exc", excepttype_o, 32'h0);
    chk("rst_flush", {31'd0, flush_o}, 32'h0);
    chk("rst_newpc", newpc_o, 32'h0);
    timer_int_i = 0; #1;
    chk("rst_int_zero", {26'd0, int_o}, 32'h0);
    ext_int_i = 6'd0; ov_i = 0;
    @(negedge clk); rst = 1;
    tick();

    // Overflow in a delay slot
    mem_valid_i = 1; mem_pc_i = 32'hBFC0_0100; mem_in_delayslot_i = 1; ov_i = 1; #1;
    chk("ov_exc", excepttype_o, 32'h0c);
    chk("ov_flush", {31'd0, flush_o}, 32'h1);
    chk("ov_newpc", newpc_o, VEC);
    chk("ov_pc", current_inst_addr_o, 32'hBFC0_0100);
    chk("ov_ds", {31'd0, is_in_delayslot_o}, 32'h1);
    chk("ov_badaddr", bad_addr_o, 32'h0);
    drain();
    mem_in_delayslot_i = 0;

    // syscall held three cycles: one pulse, FLUSH and DRAIN ignore it
    mem_valid_i = 1; syscall_i = 1; #1;
    chk("sys_c0", excepttype_o, 32'h08);
    tick();
    chk("sys_c1_flush", excepttype_o, 32'h0);
    chk("sys_c1_nf", {31'd0, flush_o}, 32'h0);
    tick();
    chk("sys_c2_drain", excepttype_o, 32'h0);
    tick();
    syscall_i = 0; ri_i = 1; #1;
    chk("back_idle_ri", excepttype_o, 32'h0a);
    drain();

    // eret with EPC written by an mtc0 in the same cycle
    mem_valid_i = 1; eret_i = 1; cp0_epc_i = 32'h1000;
    cp0_we_i = 1; cp0_waddr_i = 5'd14; cp0_wdata_i = 32'h2000; #1;
    chk("eret_exc", excepttype_o, 32'h0e);
    chk("eret_fwd_newpc", newpc_o, 32'h2000);
    drain();
    mem_valid_i = 1; eret_i = 1; #1;
    chk("eret_newpc", newpc_o, 32'h1000);
    drain();

    // Priority and bad-address selection
    mem_valid_i = 1; adel_if_i = 1; ri_i = 1; #1;
    chk("adelif_exc", excepttype_o, 32'h04);
    chk("adelif_bad", bad_addr_o, 32'h1111_1111);
    drain();
    mem_valid_i = 1; ri_i = 1; ov_i = 1; #1;
    chk("ri_over_ov", excepttype_o, 32'h0a);
    drain();
    mem_valid_i = 1; syscall_i = 1; break_i = 1; #1;
    chk("sys_over_brk", excepttype_o, 32'h08);
    drain();
    mem_valid_i = 1; break_i = 1; adel_i = 1; #1;
    chk("brk_over_adel", excepttype_o, 32'h09);
    drain();
    mem_valid_i = 1; adel_i = 1; ades_i = 1; #1;
    chk("adel_exc", excepttype_o, 32'h04);
    chk("adel_bad", bad_addr_o, 32'h2222_2222);
    drain();
    mem_valid_i = 1; ades_i = 1; eret_i = 1; #1;
    chk("ades_exc", excepttype_o, 32'h05);
    chk("ades_bad", bad_addr_o, 32'h2222_2222);
    chk("ades_newpc", newpc_o, VEC);
    drain();

    // Trap depends on build configuration
    mem_valid_i = 1; trap_i = 1; #1;
    chk("trap_exc", excepttype_o, TRAP_EXP);
    drain();
    mem_valid_i = 1; trap_i = 1; syscall_i = 1; #1;
    chk("trap_sys", excepttype_o, TRAP_SYS_EXP);
    drain();

    // Hardware interrupt through the synchronizer, taken over a simultaneous eret
    cp0_status_i = 32'h0000_FF01; mem_valid_i = 0; ext_int_i = 6'b000100;
    tick();
    chk("int_sync_1", {26'd0, int_o}, 32'h0);
    tick();
    chk("int_sync_2", {26'd0, int_o}, 32'h4);
    chk("int_invalid", excepttype_o, 32'h0);
    mem_valid_i = 1; eret_i = 1; #1;
    chk("int_over_eret", excepttype_o, 32'h01);
    chk("int_newpc", newpc_o, VEC);
    drain();

    // Software interrupt held off by stall, taken on first unstalled cycle
    cause_sw = 2'b01; mem_valid_i = 1; stall_i = 1; syscall_i = 1;
    for (int i = 0; i < 4; i++) begin
      #1 chk("int_stalled", excepttype_o, 32'h0);
      tick();
    end
    stall_i = 0; #1;
    chk("int_after_stall", excepttype_o, 32'h01);
    drain();

    // EXL masks interrupts
    cp0_status_i = 32'h0000_FF03; mem_valid_i = 1; syscall_i = 1; #1;
    chk("exl_mask", excepttype_o, 32'h08);
    drain();
    cause_sw = 2'b00;

    // Forwarded Cause write creates a pending software interrupt
    cp0_status_i = 32'h0000_FF01; mem_valid_i = 1; ov_i = 1;
    cp0_we_i = 1; cp0_waddr_i = 5'd13; cp0_wdata_i = 32'h0000_0100; #1;
    chk("fwd_cause_int", excepttype_o, 32'h01);
    drain();

    // Forwarded Status write enables and disables interrupts
    cp0_status_i = 32'h0; cause_sw = 2'b10; mem_valid_i = 1; ov_i = 1;
    cp0_we_i = 1; cp0_waddr_i = 5'd12; cp0_wdata_i = 32'h0000_0201; #1;
    chk("fwd_status_en", excepttype_o, 32'h01);
    drain();
    cp0_status_i = 32'h0000_FF01; mem_valid_i = 1; ov_i = 1;
    cp0_we_i = 1; cp0_waddr_i = 5'd12; cp0_wdata_i = 32'h0; #1;
    chk("fwd_status_dis", excepttype_o, 32'h0c);
    drain();
    cause_sw = 2'b00; cp0_status_i = 32'h0;

    // Reset during FLUSH returns straight to IDLE
    mem_valid_i = 1; syscall_i = 1; #1;
    chk("pre_rst_sys", excepttype_o, 32'h08);
    tick();
    chk("in_flush", excepttype_o, 32'h0);
    rst = 0; #1;
    chk("rst_mid_exc", excepttype_o, 32'h0);
    rst = 1; #1;
    chk("post_rst_idle", excepttype_o, 32'h08);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
